line_mem_arbiter: RTL and testbench

Parametrised N-port arbiter between cache-line clients (I-cache, D-cache, and later prefetcher/DMA) and the single cache-line adaptor port to physical memory.
- Selects one requester by round-robin or fixed priority.
- Latches that requester's command, line-aligned address and write line at grant.
- Holds the grant until the memory response, then inserts one release bubble so the client can deassert its request before the next arbitration.

---
 rtl/line_mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_line_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_mem_arbiter.sv
// N-port arbiter between cache-line clients and the single cache-line memory adaptor port.
// Round-robin or fixed-priority selection; the grant is held until mem_resp, then one release bubble.
module line_mem_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int LINE_W    = 256,
    parameter int ADDR_W    = 32,
    parameter int OFFSET_W  = 5,
    parameter int PRIO_MODE = 0,
    localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_read,
    input  logic [NUM_REQ-1:0]         req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*LINE_W-1:0]  req_wdata,
    output logic [LINE_W-1:0]          req_rdata,
    output logic [NUM_REQ-1:0]         req_resp,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [LINE_W-1:0]          mem_wdata,
    input  logic [LINE_W-1:0]          mem_rdata,
    input  logic                       mem_resp,
    output logic [ID_W-1:0]            grant_id,
    output logic                       busy,
    output logic                       proto_err
);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     gid_q, gid_d;
    logic                wr_q, wr_d;
    logic                perr_q, perr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;

    logic [NUM_REQ-1:0]  req_any;
    logic                lo_found, hi_found;
    logic [ID_W-1:0]     lo_id, hi_id, win_id;
    logic                win_rd, win_wr;
    logic [ADDR_W-1:0]   win_addr;
    logic [LINE_W-1:0]   win_wdata;

    assign req_any = req_read | req_write;

    // Round-robin as two scans: first requester above the pointer, else the lowest requester.
    always_comb begin
        lo_found = 1'b0;
        hi_found = 1'b0;
        lo_id    = '0;
        hi_id    = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (req_any[j] && !lo_found) begin
                lo_found = 1'b1;
                lo_id    = ID_W'(j);
            end
            if (req_any[j] && !hi_found && (j > 32'(ptr_q))) begin
                hi_found = 1'b1;
                hi_id    = ID_W'(j);
            end
        end
        if (PRIO_MODE == 1) win_id = lo_id;
        else                win_id = hi_found ? hi_id : lo_id;

        win_rd    = 1'b0;
        win_wr    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (ID_W'(j) == win_id) begin
                win_rd    = req_read[j];
                win_wr    = req_write[j];
                win_addr  = req_addr[j*ADDR_W +: ADDR_W];
                win_wdata = req_wdata[j*LINE_W +: LINE_W];
            end
        end
        win_addr[OFFSET_W-1:0] = '0;
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gid_d     = gid_q;
        wr_d      = wr_q;
        perr_d    = perr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        req_resp  = '0;
        req_rdata = '0;
        busy      = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (|req_any) begin
                    state_d = GRANT;
                    ptr_d   = win_id;
                    gid_d   = win_id;
                    wr_d    = win_wr;
                    addr_d  = win_addr;
                    wdata_d = win_wdata;
                    if (win_rd && win_wr) perr_d = 1'b1;
                end
            end
            GRANT: begin
                mem_read  = ~wr_q;
                mem_write = wr_q;
                if (mem_resp) begin
                    req_resp[gid_q] = 1'b1;
                    req_rdata       = mem_rdata;
                    state_d         = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= ID_W'(NUM_REQ - 1);
            gid_q   <= '0;
            wr_q    <= 1'b0;
            perr_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            wr_q    <= wr_d;
            perr_q  <= perr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign grant_id  = gid_q;
    assign proto_err = perr_q;

endmodule

// File: tb/tb_line_mem_arbiter.sv
// Scoreboard bench: a 2-port round-robin arbiter and a 4-port fixed-priority arbiter on one clock.
module tb_line_mem_arbiter;

    logic clk, rst;
    logic         mem_resp;
    logic [255:0] mem_rdata;

    logic [1:0]    a_req_read, a_req_write, a_req_resp;
    logic [63:0]   a_req_addr;
    logic [511:0]  a_req_wdata;
    logic [255:0]  a_req_rdata, a_mem_wdata;
    logic          a_mem_read, a_mem_write, a_busy, a_perr;
    logic [31:0]   a_mem_addr;
    logic [0:0]    a_gid;

    logic [3:0]    b_req_read, b_req_write, b_req_resp;
    logic [127:0]  b_req_addr;
    logic [1023:0] b_req_wdata;
    logic [255:0]  b_req_rdata, b_mem_wdata;
    logic          b_mem_read, b_mem_write, b_busy, b_perr;
    logic [31:0]   b_mem_addr;
    logic [1:0]    b_gid;

    line_mem_arbiter dut_a (
        .clk(clk), .rst(rst), .req_read(a_req_read), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_rdata(a_req_rdata),
        .req_resp(a_req_resp), .mem_read(a_mem_read), .mem_write(a_mem_write),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata),
        .mem_resp(mem_resp), .grant_id(a_gid), .busy(a_busy), .proto_err(a_perr)
    );

    line_mem_arbiter #(.NUM_REQ(4), .PRIO_MODE(1)) dut_b (
        .clk(clk), .rst(rst), .req_read(b_req_read), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_rdata(b_req_rdata),
        .req_resp(b_req_resp), .mem_read(b_mem_read), .mem_write(b_mem_write),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata),
        .mem_resp(mem_resp), .grant_id(b_gid), .busy(b_busy), .proto_err(b_perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitored view of whichever instance is under test.
    logic         sel;
    logic         m_read, m_write, m_busy, m_perr;
    logic [31:0]  m_addr;
    logic [255:0] m_wdata, m_rdata;
    logic [3:0]   m_resp;
    logic [1:0]   m_gid;

    always_comb begin
        if (sel) begin
            m_read = b_mem_read;   m_write = b_mem_write; m_busy = b_busy;   m_perr = b_perr;
            m_addr = b_mem_addr;   m_wdata = b_mem_wdata; m_rdata = b_req_rdata;
            m_resp = b_req_resp;   m_gid = b_gid;
        end else begin
            m_read = a_mem_read;   m_write = a_mem_write; m_busy = a_busy;   m_perr = a_perr;
            m_addr = a_mem_addr;   m_wdata = a_mem_wdata; m_rdata = a_req_rdata;
            m_resp = {2'b00, a_req_resp}; m_gid = {1'b0, a_gid};
        end
    end

    typedef struct {
        int           id;
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [255:0] rdata;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int id, input bit wr, input logic [31:0] addr,
                        input logic [255:0] wdata, input logic [255:0] rdata);
        exp_t e;
        e.id = id; e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
        sb.push_back(e);
    endtask

    task automatic wait_active(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(m_read || m_write) && k < 40);
    endtask

    // Called just after a rising edge; returns just after the edge that enters IDLE again.
    task automatic serve(input int lat, input bit scramble);
        exp_t e;
        int   k;
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        wait_active(k);
        check("start_latency", k, 2);
        check("grant_id", m_gid, e.id);
        check("mem_read", m_read, !e.wr);
        check("mem_write", m_write, e.wr);
        check("mem_addr", m_addr, e.addr);
        check("mem_wdata", m_wdata, e.wdata);
        check("busy_grant", m_busy, 1);
        repeat (lat) begin
            @(posedge clk); #1;
            if (scramble) begin
                a_req_addr  = {$urandom, $urandom};
                for (int i = 0; i < 16; i++) a_req_wdata[i*32 +: 32] = $urandom;
                a_req_read  = '0;
                a_req_write = '0;
            end
            @(negedge clk);
            check("hold_addr", m_addr, e.addr);
            check("hold_wdata", m_wdata, e.wdata);
            check("hold_write", m_write, e.wr);
            check("no_early_resp", m_resp, 0);
        end
        @(posedge clk); #1;
        mem_resp  = 1'b1;
        mem_rdata = e.rdata;
        @(negedge clk);
        check("req_resp", m_resp, 256'(1) << e.id);
        check("req_rdata", m_rdata, e.rdata);
        @(posedge clk); #1;
        @(negedge clk);
        check("release_busy", m_busy, 1);
        check("release_mem_op", m_read | m_write, 0);
        check("release_resp", m_resp, 0);
        check("release_rdata", m_rdata, 0);
        @(posedge clk); #1;
        mem_resp  = 1'b0;
        mem_rdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [255:0] pat_a5, pat_dead, pat_rand;
        pat_a5   = {32{8'hA5}};
        pat_dead = {8{32'hDEADBEEF}};
        sel = 1'b0;
        rst = 1'b1;
        mem_resp = 1'b0; mem_rdata = '0;
        a_req_read = '0; a_req_write = '0; a_req_addr = '0; a_req_wdata = '0;
        b_req_read = '0; b_req_write = '0; b_req_addr = '0; b_req_wdata = '0;

        @(negedge clk);
        check("rst_busy", a_busy, 0);
        check("rst_mem_read", a_mem_read, 0);
        check("rst_mem_write", a_mem_write, 0);
        check("rst_resp", a_req_resp, 0);
        check("rst_gid", a_gid, 0);
        check("rst_perr", a_perr, 0);
        check("rst_b_gid", b_gid, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single read by client 1.
        a_req_read = 2'b10;
        a_req_addr[32 +: 32] = 32'h0000_1234;
        push(1, 0, 32'h0000_1220, '0, pat_a5);
        serve(1, 0);
        a_req_read = '0;
        @(negedge clk);
        check("idle_busy", a_busy, 0);
        check("idle_mem_read", a_mem_read, 0);

        // Round-robin with both clients held from reset.
        @(posedge clk); #1;
        rst = 1'b1;
        a_req_read = 2'b11;
        a_req_addr = {32'h0000_2047, 32'h0000_1011};
        for (int i = 0; i < 16; i++) a_req_wdata[i*32 +: 32] = 32'h1000_0000 + i;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            pat_rand = {8{$urandom}};
            if (n % 2 == 0) push(0, 0, 32'h0000_1000, a_req_wdata[255:0], pat_rand);
            else            push(1, 0, 32'h0000_2040, a_req_wdata[511:256], pat_rand);
            serve(n, 0);
        end
        a_req_read = '0;
        @(negedge clk);
        check("perr_clear", a_perr, 0);

        // Write by client 0 with its inputs scrambled mid-transaction.
        @(posedge clk); #1;
        a_req_write = 2'b01;
        a_req_addr[31:0]    = 32'h8000_0040;
        a_req_wdata[255:0]  = pat_dead;
        push(0, 1, 32'h8000_0040, pat_dead, pat_a5);
        serve(3, 1);
        a_req_read = '0; a_req_write = '0;

        // Read and write together: write wins, sticky proto_err.
        @(posedge clk); #1;
        a_req_read = 2'b01; a_req_write = 2'b01;
        a_req_addr[31:0]   = 32'h0000_011F;
        a_req_wdata[255:0] = pat_a5;
        push(0, 1, 32'h0000_0100, pat_a5, pat_dead);
        serve(0, 0);
        a_req_read = '0; a_req_write = '0;
        @(negedge clk);
        check("perr_sticky", a_perr, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("perr_still", a_perr, 1);

        // Asynchronous reset in the middle of a grant to client 0.
        @(posedge clk); #1;
        a_req_read = 2'b01;
        wait_active(k);
        check("pre_rst_latency", k, 2);
        #2;
        rst = 1'b1;
        #1;
        check("async_mem_read", a_mem_read, 0);
        check("async_busy", a_busy, 0);
        check("async_resp", a_req_resp, 0);
        check("async_perr", a_perr, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        a_req_read = '0;
        mem_resp = 1'b1; mem_rdata = pat_dead;
        @(negedge clk);
        check("stray_resp", a_req_resp, 0);
        check("stray_rdata", a_req_rdata, 0);
        check("stray_busy", a_busy, 0);
        @(posedge clk); #1;
        mem_resp = 1'b0; mem_rdata = '0;
        a_req_read = 2'b11;
        push(0, 0, a_req_addr[31:0] & 32'hFFFF_FFE0, a_req_wdata[255:0], pat_a5);
        serve(1, 0);
        a_req_read = '0;

        // Fixed priority on the 4-port instance.
        @(posedge clk); #1;
        sel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_req_addr[i*32 +: 32]   = 32'h100 * i + 32'h3F;
            b_req_wdata[i*256 +: 256] = {8{32'hC000_0000 + i}};
        end
        b_req_read = 4'b1110;
        for (int n = 0; n < 3; n++) begin
            push(1, 0, 32'h0000_0120, b_req_wdata[256 +: 256], {8{$urandom}});
            serve(n, 0);
        end
        b_req_read = 4'b1100;
        push(2, 0, 32'h0000_0220, b_req_wdata[512 +: 256], pat_a5);
        serve(1, 0);
        b_req_read = '0;
        @(negedge clk);
        check("b_idle_busy", b_busy, 0);
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
